axis_stream_fifo: RTL
=====================

// Module: axis_stream_fifo
// PURPOSE
//  Synchronous first-word-fall-through FIFO with AXI-Stream valid/ready on both sides,
//  carrying data plus TLAST. Buffers between the DMA stream engine and its consumer/producer.
//  Adds occupancy level, programmable almost-full/almost-empty flags, complete-packet
//  count and synchronous flush to the plain wr_en/rd_en FIFO.
// PARAMETERS
//  DATA_WIDTH   32  TDATA width in bits (>=1)
//  FIFO_DEPTH   16  entries; power of two, >=2
//  AF_THRESH    12  almost_full asserted when level >= AF_THRESH (1..FIFO_DEPTH)
//  AE_THRESH     4  almost_empty asserted when level <= AE_THRESH (0..FIFO_DEPTH-1)
// PORTS
//  clk           in   1                clock, all logic on rising edge
//  reset         in   1                synchronous reset, active-high
//  flush         in   1                synchronous clear of contents, active-high
//  s_axis_tdata  in   DATA_WIDTH       write data
//  s_axis_tlast  in   1                write end-of-packet
//  s_axis_tvalid in   1                write valid
//  s_axis_tready out  1                write ready (not full)
//  m_axis_tdata  out  DATA_WIDTH       head-of-FIFO data (FWFT)
//  m_axis_tlast  out  1                head-of-FIFO TLAST
//  m_axis_tvalid out  1                head valid (not empty)
//  m_axis_tready in   1                read ready
//  level         out  $clog2(D)+1      entries currently stored, 0..FIFO_DEPTH
//  almost_full   out  1                level >= AF_THRESH
//  almost_empty  out  1                level <= AE_THRESH
//  pkt_count     out  $clog2(D)+1      number of entries with TLAST=1 currently stored
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (clk, reset).
//  - Reset (and flush): wr_ptr=rd_ptr=0, level=0, pkt_count=0; hence s_axis_tready=1,
//    m_axis_tvalid=0, almost_full=0 (AF_THRESH>=1), almost_empty=1. Memory not cleared;
//    m_axis_tdata/tlast undefined while m_axis_tvalid=0.
//  - Pointers ADDR_WIDTH+1 bits (extra wrap bit); level = wr_ptr - rd_ptr, registered.
//  - Write accepted iff s_axis_tvalid && s_axis_tready; s_axis_tready = (level != FIFO_DEPTH),
//    no combinational path from s_axis_tvalid or m_axis_tready.
//  - Read accepted iff m_axis_tvalid && m_axis_tready; m_axis_tvalid = (level != 0).
//  - m_axis_tdata/tlast = mem[rd_ptr] combinationally (FWFT): a word written at edge N is
//    visible with m_axis_tvalid=1 after edge N (latency 1 cycle, write to output).
//  - Simultaneous write and read accepted: level unchanged; legal at any non-empty,
//    non-full level. Full: write blocked, read proceeds. Empty: no read, write proceeds.
//  - Pointers wrap naturally modulo 2*FIFO_DEPTH; no special case at wrap.
//  - pkt_count: +1 on accepted write with tlast=1, -1 on accepted read with tlast=1,
//    both in same cycle -> unchanged. Never exceeds level.
//  - almost_full/almost_empty derived combinationally from registered level.
//  - flush has priority over reset-free handshakes: a write/read in the flush cycle is
//    discarded/ignored; next cycle FIFO is empty. reset has priority over flush.
//  - Reset mid-packet: all stored data and partial packets dropped, no recovery.
//  - No overflow/underflow possible by construction; no error outputs.
// STRUCTURE
//  - Shared package axis_dma_pkg: clog2-based ADDR_WIDTH helper, default DATA_WIDTH/
//    FIFO_DEPTH constants, parameter-legality checks (power-of-two depth, threshold range).
//  - Sub-module axis_fifo_ram: DEPTH x (DATA_WIDTH+1) simple dual-port RAM, synchronous
//    write, asynchronous read; top holds pointers, level, pkt_count and flags.
// TESTING
//  1 Reset then idle -> tready=1, tvalid=0, level=0, almost_empty=1, almost_full=0, pkt_count=0.
//  2 Write 16 words 0x0..0xF (last on 0xF), tready_m=0 -> level=16, tready=0, almost_full=1,
//    pkt_count=1; 17th write held off; then drain -> read order 0x0..0xF, tlast only on 0xF.
//  3 Continuous write+read at level 8 for 100 cycles -> level stays 8, data in order,
//    pointers wrap cleanly past 2*DEPTH.
//  4 Single write of 0xA5 into empty FIFO -> tvalid=1 and tdata=0xA5 the cycle after accept.
//  5 Level 10 with 2 packets, assert flush with concurrent write -> next cycle level=0,
//    pkt_count=0, tvalid=0, flushed-cycle word absent from later output.
//  6 Random valid/ready both sides, 10k beats vs scoreboard -> no loss/dup/reorder,
//    level and pkt_count match model every cycle; reset asserted mid-run -> state per test 1.

Source files
------------

// File: rtl/axis_dma_pkg.sv
// Shared constants and elaboration helpers for the AXI-Stream DMA buffering blocks.
package axis_dma_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

    // Address bits needed to index a memory of the given depth (at least one bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    // Depth must be a power of two >= 2 so the wrap-bit pointer scheme works unmodified.
    function automatic bit fifo_params_ok(input int unsigned data_width,
                                          input int unsigned depth,
                                          input int unsigned af_thresh,
                                          input int unsigned ae_thresh);
        return (data_width >= 1) && (depth >= 2) && is_pow2(depth) &&
               (af_thresh >= 1) && (af_thresh <= depth) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read for first-word-fall-through.
module axis_fifo_ram
    import axis_dma_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH + 1,
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             wr_en,
    input  logic [addr_width(DEPTH)-1:0]     wr_addr,
    input  logic [WIDTH-1:0]                 wr_data,
    input  logic [addr_width(DEPTH)-1:0]     rd_addr,
    output logic [WIDTH-1:0]                 rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are intentionally never cleared; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_stream_fifo.sv
// First-word-fall-through AXI-Stream FIFO carrying TDATA+TLAST, with occupancy level,
// almost-full/almost-empty flags, stored complete-packet count and synchronous flush.
module axis_stream_fifo
    import axis_dma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned AF_THRESH  = 12,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [addr_width(FIFO_DEPTH):0]   level,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic [addr_width(FIFO_DEPTH):0]   pkt_count
);

    localparam int unsigned AW = addr_width(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    if (!fifo_params_ok(DATA_WIDTH, FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : gen_bad_params
        $error("axis_stream_fifo: illegal DATA_WIDTH/FIFO_DEPTH/AF_THRESH/AE_THRESH");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic [AW:0] pkt_q, pkt_d;

    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH:0]   rd_word;

    // Ready/valid depend only on the registered level: no combinational input-to-output path.
    assign s_axis_tready = (level_q != LW'(FIFO_DEPTH));
    assign m_axis_tvalid = (level_q != '0);
    assign wr_acc        = s_axis_tvalid && s_axis_tready;
    assign rd_acc        = m_axis_tvalid && m_axis_tready;

    assign m_axis_tdata  = rd_word[DATA_WIDTH-1:0];
    assign m_axis_tlast  = rd_word[DATA_WIDTH];

    assign level         = level_q;
    assign pkt_count     = pkt_q;
    assign almost_full   = (level_q >= LW'(AF_THRESH));
    assign almost_empty  = (level_q <= LW'(AE_THRESH));

    // Next-state pointers, level and packet count; flush discards the cycle's handshakes.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (wr_acc ? LW'(1) : LW'(0));
        rd_ptr_d = rd_ptr_q + (rd_acc ? LW'(1) : LW'(0));
        pkt_d    = pkt_q;
        unique case ({wr_acc && s_axis_tlast, rd_acc && m_axis_tlast})
            2'b10:   pkt_d = pkt_q + LW'(1);
            2'b01:   pkt_d = pkt_q - LW'(1);
            default: pkt_d = pkt_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pkt_d    = '0;
        end
        level_d = wr_ptr_d - rd_ptr_d;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pkt_q    <= pkt_d;
        end
    end

    axis_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc && !flush && !reset),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_word)
    );

endmodule
